// File: rtl/synth_pkg.sv
// Shared widths, FSM state encoding and coefficient record for the
// time-multiplexed additive-synthesis sequencer.
package synth_pkg;

  localparam int NUM_HARM_MAX = 15;
  localparam int ACC_W        = 24;
  localparam int ROM_AW       = 8;
  localparam int ROM_DW       = 16;
  localparam int MAG_W        = 4;
  localparam int IDX_W        = 4;
  localparam int PHASE_W      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [MAG_W-1:0] sin_mag;
    logic signed [MAG_W-1:0] cos_mag;
  } coef_t;

  // (k+1)*p mod 256 is reached from k*p by one add, so no multiplier is needed.
  function automatic logic [ROM_AW-1:0] next_harm_addr(
    input logic [ROM_AW-1:0] addr,
    input logic [ROM_AW-1:0] phase
  );
    return addr + phase;
  endfunction

endpackage

// File: rtl/harmonic_mac.sv
// Multiply-accumulate for one harmonic term per cycle: sine and cosine
// products with signed 4-bit magnitudes, summed into a clearable accumulator.
module harmonic_mac
  import synth_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [ROM_DW-1:0] rom_sine,
  input  logic signed [ROM_DW-1:0] rom_cosine,
  input  logic signed [MAG_W-1:0]  sin_mag,
  input  logic signed [MAG_W-1:0]  cos_mag,
  output logic signed [ACC_W-1:0]  sum_next
);

  localparam int PW = ROM_DW + MAG_W;
  localparam int TW = PW + 1;

  logic signed [PW-1:0]    prod_sin_s;
  logic signed [PW-1:0]    prod_cos_s;
  logic signed [TW-1:0]    term_s;
  logic signed [ACC_W-1:0] term_ext_s;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;

  // Term formation and next accumulator value.
  always_comb begin
    prod_sin_s = PW'(rom_sine) * PW'(sin_mag);
    prod_cos_s = PW'(rom_cosine) * PW'(cos_mag);
    term_s     = TW'(prod_sin_s) + TW'(prod_cos_s);
    term_ext_s = ACC_W'(term_s);
    if (en) begin
      sum_next = acc_q + term_ext_s;
    end else begin
      sum_next = acc_q;
    end
    if (clr) begin
      acc_d = '0;
    end else begin
      acc_d = sum_next;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/harmonic_sequencer.sv
// Additive-synthesis controller: one shared sine/cosine ROM walked over
// harmonics 1..N per sample tick, with double-buffered coefficients.
module harmonic_sequencer
  import synth_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sample_tick,
  input  logic [PHASE_W-1:0]        freq_step,
  input  logic [IDX_W-1:0]          num_harm,
  input  logic                      coef_we,
  input  logic [IDX_W-1:0]          coef_addr,
  input  logic signed [MAG_W-1:0]   coef_sin,
  input  logic signed [MAG_W-1:0]   coef_cos,
  output logic [ROM_AW-1:0]         rom_addr,
  input  logic signed [ROM_DW-1:0]  rom_sine,
  input  logic signed [ROM_DW-1:0]  rom_cosine,
  output logic signed [ACC_W-1:0]   sample_out,
  output logic                      sample_valid,
  output logic                      busy,
  output logic                      overrun,
  input  logic                      overrun_clr
);

  state_e state_q, state_d;

  logic [IDX_W-1:0]   k_q, k_d;
  logic [IDX_W-1:0]   n_q, n_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [ROM_AW-1:0]  phase_q, phase_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  logic               mac_vld_q, mac_vld_d;
  logic [IDX_W-1:0]   mac_k_q, mac_k_d;

  logic signed [ACC_W-1:0] sample_out_q, sample_out_d;
  logic               sample_valid_q, sample_valid_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;

  // Entry 0 is never written, so it stays zero and is trimmed away.
  coef_t shadow_q [0:NUM_HARM_MAX];
  coef_t shadow_d [0:NUM_HARM_MAX];
  coef_t active_q [0:NUM_HARM_MAX];
  coef_t active_d [0:NUM_HARM_MAX];

  logic                    accept_s;
  logic                    mac_clr_s;
  logic signed [ACC_W-1:0] mac_sum_s;
  coef_t                   mac_coef_s;

  assign accept_s   = sample_tick && (state_q == IDLE);
  assign mac_coef_s = active_q[mac_k_q];

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (num_harm == 4'd0) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (k_q == n_q) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: sample capture, valid pulse, busy and sticky overrun.
  always_comb begin
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    busy_d         = (state_d != IDLE);
    overrun_d      = overrun_q;
    case (state_q)
      DRAIN: begin
        sample_out_d   = mac_sum_s;
        sample_valid_d = 1'b1;
      end
      IDLE, RUN: begin
        sample_out_d   = sample_out_q;
        sample_valid_d = 1'b0;
      end
      default: begin
        sample_out_d   = sample_out_q;
        sample_valid_d = 1'b0;
      end
    endcase
    if (sample_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Phase accumulator, harmonic counter, ROM address and MAC sequencing.
  always_comb begin
    k_d        = k_q;
    n_d        = n_q;
    acc_d      = acc_q;
    phase_d    = phase_q;
    rom_addr_d = rom_addr_q;
    mac_vld_d  = 1'b0;
    mac_k_d    = mac_k_q;
    mac_clr_s  = 1'b0;
    if (accept_s) begin
      phase_d   = acc_q[PHASE_W-1:PHASE_W-ROM_AW];
      acc_d     = acc_q + freq_step;
      n_d       = num_harm;
      k_d       = 4'd1;
      mac_clr_s = 1'b1;
      if (num_harm != 4'd0) begin
        rom_addr_d = acc_q[PHASE_W-1:PHASE_W-ROM_AW];
      end else begin
        rom_addr_d = rom_addr_q;
      end
    end else if (state_q == RUN) begin
      mac_vld_d = 1'b1;
      mac_k_d   = k_q;
      if (k_q != n_q) begin
        k_d        = k_q + 4'd1;
        rom_addr_d = next_harm_addr(rom_addr_q, phase_q);
      end else begin
        k_d        = k_q;
        rom_addr_d = rom_addr_q;
      end
    end else begin
      mac_vld_d = 1'b0;
    end
  end

  // Coefficient banks: writes go to shadow, shadow snaps to active on accept.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (coef_we && (coef_addr != 4'd0)) begin
      shadow_d[coef_addr] = '{sin_mag: coef_sin, cos_mag: coef_cos};
    end else begin
      shadow_d = shadow_q;
    end
    if (accept_s) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q            <= 4'd0;
      n_q            <= 4'd0;
      acc_q          <= 16'd0;
      phase_q        <= 8'd0;
      rom_addr_q     <= 8'd0;
      mac_vld_q      <= 1'b0;
      mac_k_q        <= 4'd0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      for (int i = 0; i <= NUM_HARM_MAX; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      k_q            <= k_d;
      n_q            <= n_d;
      acc_q          <= acc_d;
      phase_q        <= phase_d;
      rom_addr_q     <= rom_addr_d;
      mac_vld_q      <= mac_vld_d;
      mac_k_q        <= mac_k_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
    end
  end

  harmonic_mac u_mac (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (mac_clr_s),
    .en         (mac_vld_q),
    .rom_sine   (rom_sine),
    .rom_cosine (rom_cosine),
    .sin_mag    (mac_coef_s.sin_mag),
    .cos_mag    (mac_coef_s.cos_mag),
    .sum_next   (mac_sum_s)
  );

  assign rom_addr     = rom_addr_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Directed bench for harmonic_sequencer with a registered ROM model
// (sine = {addr, 8'h00}, cosine = 1, or both forced to -32768).
module tb_harmonic_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_tick;
  logic [15:0] freq_step;
  logic [3:0]  num_harm;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [3:0]  coef_sin;
  logic [3:0]  coef_cos;
  logic [7:0]  rom_addr;
  logic [15:0] rom_sine = 16'd0;
  logic [15:0] rom_cosine = 16'd0;
  logic [23:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
  logic        overrun_clr;
  logic        rom_force = 1'b0;

  int checks   = 0;
  int failures = 0;
  logic [7:0] addr_log [0:47];

  harmonic_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_tick  (sample_tick),
    .freq_step    (freq_step),
    .num_harm     (num_harm),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_sin     (coef_sin),
    .coef_cos     (coef_cos),
    .rom_addr     (rom_addr),
    .rom_sine     (rom_sine),
    .rom_cosine   (rom_cosine),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_force) begin
      rom_sine   <= 16'h8000;
      rom_cosine <= 16'h8000;
    end else begin
      rom_sine   <= {rom_addr, 8'h00};
      rom_cosine <= 16'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_coef(input logic [3:0] k, input logic [3:0] s, input logic [3:0] c);
    coef_we = 1'b1; coef_addr = k; coef_sin = s; coef_cos = c;
    step();
    coef_we = 1'b0;
  endtask

  task automatic rst_pulse();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  // One frame: tick in cycle 0, optional coef write / extra tick / overrun_clr
  // at given cycle offsets, then latency, value and pulse-width checks.
  task automatic frame(input logic [3:0] n, input logic [23:0] exp, input int wr_at,
                       input logic [3:0] wk, input logic [3:0] ws, input logic [3:0] wc,
                       input int t2_at, input int clr_at, input string tag);
    int c;
    c = 0;
    num_harm = n; sample_tick = 1'b1;
    coef_we = (wr_at == 0); coef_addr = wk; coef_sin = ws; coef_cos = wc;
    overrun_clr = (clr_at == 0);
    step();
    c = 1;
    sample_tick = 1'b0; coef_we = 1'b0; overrun_clr = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    addr_log[1] = rom_addr;
    while (sample_valid !== 1'b1 && c < 40) begin
      coef_we     = (wr_at == c);
      sample_tick = (t2_at == c);
      overrun_clr = (clr_at == c);
      step();
      coef_we = 1'b0; sample_tick = 1'b0; overrun_clr = 1'b0;
      c++;
      addr_log[c] = rom_addr;
    end
    chk({tag, "_latency"}, 32'(c), 32'(n) + 32'd2);
    chk({tag, "_sample"}, {8'h00, sample_out}, {8'h00, exp});
    step();
    chk({tag, "_pulse"}, 32'(sample_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0; sample_tick = 1'b0; freq_step = 16'd0; num_harm = 4'd0;
    coef_we = 1'b0; coef_addr = 4'd0; coef_sin = 4'd0; coef_cos = 4'd0;
    overrun_clr = 1'b0;
    step(); step();
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_sample", {8'h00, sample_out}, 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    step();

    // Single harmonic, phase 0 then phase 1.
    freq_step = 16'h0100;
    wr_coef(4'd1, 4'd1, 4'd0);
    frame(4'd1, 24'd0, -1, 4'd0, 4'd0, 4'd0, -1, -1, "h1_f0");
    frame(4'd1, 24'd256, -1, 4'd0, 4'd0, 4'd0, -1, -1, "h1_f1");
    chk("h1_f1_addr", 32'(addr_log[1]), 32'h01);

    // Zero harmonics: valid at T+2 with a zero sample.
    frame(4'd0, 24'd0, -1, 4'd0, 4'd0, 4'd0, -1, -1, "h0");

    // Three harmonics after acc preset by step 0x1000.
    rst_pulse();
    freq_step = 16'h1000;
    wr_coef(4'd1, 4'd1, 4'd2);
    wr_coef(4'd2, 4'd1, 4'd2);
    wr_coef(4'd3, 4'd1, 4'd2);
    frame(4'd3, 24'd6, -1, 4'd0, 4'd0, 4'd0, -1, -1, "h3_f0");
    frame(4'd3, 24'd24582, -1, 4'd0, 4'd0, 4'd0, -1, -1, "h3_f1");
    chk("h3_addr1", 32'(addr_log[1]), 32'h10);
    chk("h3_addr2", 32'(addr_log[2]), 32'h20);
    chk("h3_addr3", 32'(addr_log[3]), 32'h30);
    step(); step();
    chk("idle_addr_hold", 32'(rom_addr), 32'h30);

    // Overrun: tick at T+2 (with simultaneous clear) is ignored, flag sticks.
    frame(4'd3, 24'd49158, -1, 4'd0, 4'd0, 4'd0, 2, 2, "ovr_f");
    chk("ovr_set", 32'(overrun), 32'd1);
    frame(4'd3, 24'd8198, -1, 4'd0, 4'd0, 4'd0, -1, -1, "ovr_next");
    chk("ovr_next_addr1", 32'(addr_log[1]), 32'h30);
    chk("ovr_next_addr3", 32'(addr_log[3]), 32'h90);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    // Shadow coefficients: mid-frame and accept-cycle writes apply next frame.
    rst_pulse();
    freq_step = 16'h0000;
    wr_coef(4'd1, 4'd0, 4'd1);
    frame(4'd2, 24'd1, 1, 4'd1, 4'd0, 4'd5, -1, -1, "shd_mid");
    frame(4'd2, 24'd5, 0, 4'd1, 4'd0, 4'd7, -1, -1, "shd_acc");
    frame(4'd2, 24'd7, -1, 4'd0, 4'd0, 4'd0, -1, -1, "shd_new");

    // Extremes: ROM and every magnitude at the most negative value.
    rst_pulse();
    freq_step = 16'h0300;
    for (int k = 1; k <= 15; k++) begin
      wr_coef(4'(k), 4'h8, 4'h8);
    end
    rom_force = 1'b1;
    frame(4'd15, 24'h780000, -1, 4'd0, 4'd0, 4'd0, -1, -1, "ext");
    rom_force = 1'b0;

    // Reset mid-frame at T+3 aborts the frame.
    num_harm = 4'd15; sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("mid_pre_overrun", 32'(overrun), 32'd1);
    chk("mid_pre_addr", 32'(rom_addr), 32'h09);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_sample", {8'h00, sample_out}, 32'd0);
    chk("mid_rst_valid", 32'(sample_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    step(); step();
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      step();
      if (sample_valid === 1'b1) seen = 1'b1;
    end
    chk("mid_no_valid", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/harmonic_sequencer.md
# harmonic_sequencer

Time-multiplexed additive-synthesis controller that shares one synchronous sine/cosine ROM across up to 15 harmonics. On each sample tick it latches a fundamental phase, walks harmonics 1..num_harm, and drives ROM address k·phase for each harmonic k. It multiply-accumulates the returned sine/cosine values with per-harmonic signed 4-bit magnitudes and emits one summed sample. It sits between the coefficient-programming interface and the audio output path, replacing one phasor instance per harmonic.

## Interface
- NUM_HARM_MAX, 15, highest harmonic index supported (fixed by the 4-bit index).
- ACC_W, 24, accumulator and sample width. Worst case 15·2·32768·8 = 7,864,320 < 2^23, so no overflow is possible.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle request to start a frame.
- freq_step  in  16  fundamental phase increment applied per accepted tick.
- num_harm  in  4  harmonics per frame; latched at accept.
- coef_we  in  1  shadow coefficient write strobe.
- coef_addr  in  4  harmonic index; writes to 0 are ignored.
- coef_sin, coef_cos  in  4 each  signed magnitudes.
- rom_addr  out  8  ROM address.
- rom_sine, rom_cosine  in  16 each  signed ROM data, valid one cycle after rom_addr.
- sample_out  out  ACC_W  signed summed sample.
- sample_valid  out  1  one-cycle pulse marking a new sample_out.
- busy  out  1  high while a frame is in progress.
- overrun  out  1  sticky flag: a tick arrived while busy.
- overrun_clr  in  1  clears overrun.

## Operation
- **Phase accumulator:** 16 bits. Phase p = acc[15:8]. On tick accept:
  - frame_phase ← p
  - acc ← acc + freq_step (wraps mod 2^16)
- **Coefficients:** double-buffered.
  - Writes always land in the shadow bank.
  - Shadow is copied to the active bank on tick accept.
  - A write in the accept cycle itself lands in shadow only and takes effect next frame.
- **Address:** rom_addr = (k · frame_phase) mod 256.
- **MAC per harmonic:** term = rom_sine·sin_mag[k] + rom_cosine·cos_mag[k], sign-extended to ACC_W and summed.
- **States:**
  - IDLE: tick → RUN (k←1, acc_sum←0); if latched num_harm == 0 → DRAIN instead.
  - RUN: issues k; when k == N → DRAIN, else k++.
  - DRAIN: adds the last term, registers sample_out, pulses sample_valid → IDLE.
- busy = (state ≠ IDLE).
- **Tick while busy:** tick is ignored, frame is unaffected, overrun ← 1. Same-cycle overrun_clr and overrun set → set wins.
- rom_addr holds its last value in IDLE.
- **Reset values:** rom_addr 0, sample_out 0, sample_valid 0, busy 0, overrun 0, phase 0, both coefficient banks 0, state IDLE.
- **Reset mid-frame:** frame is aborted and produces no valid pulse.

## Timing
- Tick sampled in IDLE at cycle T.
  - rom_addr for harmonic k is driven in cycle T+k.
  - ROM data for k arrives in T+k+1 and is accumulated at the end of that cycle.
  - sample_valid is high in cycle T+N+2.
- busy is high in T+1..T+N+1; the next tick is accepted in T+N+2 or later.
- num_harm == 0: no ROM-qualified MAC; sample_out = 0 with valid in T+2.
- sample_out holds its value until the next valid pulse.

## Structure
- **Package synth_pkg:** NUM_HARM_MAX, ACC_W, ROM address/data widths, state enum (IDLE, RUN, DRAIN).
- **Sub-module harmonic_mac:** two signed 16×4 products, sum, accumulate, with clear/enable controls.
- **Top-level:** FSM, phase accumulator, and coefficient banks.

## Test plan
Bench ROM model: rom_sine = {addr, 8'h00}, rom_cosine = 1, registered with one-cycle latency.
- **Single harmonic.** num_harm=1, coef k1 = (1, 0), freq_step=0x0100.
  - Frame 0: sample_out 0, valid at T+3.
  - Frame 1: 256.
- **Three harmonics.** num_harm=3, all coefs = (1, 2), acc preset via step 0x1000.
  - Second frame addresses 0x10, 0x20, 0x30.
  - sample_out = 4096 + 8192 + 12288 + 6 = 24582, valid at T+5.
- **Extremes.** ROM forced to −32768/−32768, all mags −8, num_harm=15 → 7,864,320 with no wrap.
- **Overrun.** Tick at T+2 of a busy frame:
  - frame result unchanged;
  - overrun=1 until overrun_clr;
  - phase advanced only once.
- **Shadow write.** Write to k1 mid-frame:
  - current sample uses old coefs;
  - next frame uses new coefs.
- **Reset mid-frame.** reset_n low at T+3 → all outputs return to reset values immediately; no sample_valid follows.
